// File: rtl/fifo_pack_pkg.sv
// fifo_pack_pkg: shared state encoding and FIFO word layout for the write packer and read unpacker.
package fifo_pack_pkg;

    typedef enum logic [1:0] {EMPTY, FILL, HOLD} pack_state_e;

    function automatic int fifo_width(input int out_w, input int llog2);
        return out_w + 1 + llog2;
    endfunction

    function automatic int nlanes_lsb(input int out_w);
        return out_w;
    endfunction

    function automatic int last_bit(input int out_w, input int llog2);
        return out_w + llog2;
    endfunction

endpackage

// File: rtl/fifo_wr_packer.sv
// fifo_wr_packer: packs RATIO input lanes into one word and writes {last, nlanes-1, word}
// into an async FIFO write port through a single hold register.
module fifo_wr_packer
    import fifo_pack_pkg::*;
#(
    parameter int IN_WIDTH   = 8,
    parameter int RATIO      = 4,
    parameter int LLOG2      = 2,
    localparam int OUT_WIDTH  = IN_WIDTH * RATIO,
    localparam int FIFO_WIDTH = fifo_width(OUT_WIDTH, LLOG2)
) (
    input  logic                  wrclk,
    input  logic                  aclr,
    input  logic [IN_WIDTH-1:0]   in_data,
    input  logic                  in_valid,
    input  logic                  in_last,
    output logic                  in_ready,
    input  logic                  flush,
    output logic [FIFO_WIDTH-1:0] fifo_data,
    output logic                  fifo_wrreq,
    input  logic                  fifo_wr_full,
    output logic [15:0]           word_count,
    output logic [15:0]           pkt_count
);

    localparam int LAST_BIT = last_bit(OUT_WIDTH, LLOG2);
    localparam int NL_LSB   = nlanes_lsb(OUT_WIDTH);

    pack_state_e           state_q, state_d;
    logic [LLOG2-1:0]      cnt_q, cnt_d;
    logic [OUT_WIDTH-1:0]  asm_q, asm_d;
    logic [FIFO_WIDTH-1:0] hold_q, hold_d;
    logic [15:0]           word_count_q, word_count_d;
    logic [15:0]           pkt_count_q, pkt_count_d;
    logic                  hold_valid, accept, close;
    logic [OUT_WIDTH-1:0]  merged;
    logic [FIFO_WIDTH-1:0] word;

    assign hold_valid = (state_q == HOLD);
    assign in_ready   = !hold_valid || !fifo_wr_full;
    assign fifo_wrreq = hold_valid && !fifo_wr_full;
    assign fifo_data  = hold_q;
    assign word_count = word_count_q;
    assign pkt_count  = pkt_count_q;

    always_comb begin
        accept = in_valid && in_ready;
        merged = asm_q;
        for (int k = 0; k < RATIO; k++)
            if (accept && cnt_q == LLOG2'(k)) merged[k*IN_WIDTH +: IN_WIDTH] = in_data;
        // a flush-only closure must not overwrite a held word that cannot drain this cycle
        close = accept ? (cnt_q == LLOG2'(RATIO-1) || in_last || flush)
                       : (flush && cnt_q != '0 && in_ready);
        word = '0;
        word[OUT_WIDTH-1:0] = merged;
        word[NL_LSB +: LLOG2] = accept ? cnt_q : cnt_q - LLOG2'(1);
        word[LAST_BIT] = accept && in_last;
        cnt_d = close ? '0 : cnt_q + LLOG2'(accept);
        asm_d = close ? '0 : merged;
        hold_d = close ? word : hold_q;
        state_d = (close || (hold_valid && !fifo_wrreq)) ? HOLD : (cnt_d != '0 ? FILL : EMPTY);
        word_count_d = word_count_q + 16'(fifo_wrreq);
        pkt_count_d = pkt_count_q + 16'(fifo_wrreq && hold_q[LAST_BIT]);
    end

    always_ff @(posedge wrclk or negedge aclr) begin
        if (!aclr) begin
            state_q      <= EMPTY;
            cnt_q        <= '0;
            asm_q        <= '0;
            hold_q       <= '0;
            word_count_q <= '0;
            pkt_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            asm_q        <= asm_d;
            hold_q       <= hold_d;
            word_count_q <= word_count_d;
            pkt_count_q  <= pkt_count_d;
        end
    end

endmodule

// File: tb/tb_fifo_wr_packer.sv
// tb_fifo_wr_packer: directed checks of lane packing, stalls, flush, reset and counter wrap.
module tb_fifo_wr_packer;

    logic        wrclk = 0, aclr = 0;
    logic [7:0]  in_data = 0;
    logic        in_valid = 0, in_last = 0, flush = 0, fifo_wr_full = 0;
    logic        in_ready, fifo_wrreq;
    logic [34:0] fifo_data;
    logic [15:0] word_count, pkt_count;
    int          total = 0, bad = 0;
    bit          mon_en = 1;
    logic [34:0] got_q[$], exp_q[$];

    always #5 wrclk = ~wrclk;

    fifo_wr_packer dut (
        .wrclk(wrclk), .aclr(aclr), .in_data(in_data), .in_valid(in_valid),
        .in_last(in_last), .in_ready(in_ready), .flush(flush), .fifo_data(fifo_data),
        .fifo_wrreq(fifo_wrreq), .fifo_wr_full(fifo_wr_full),
        .word_count(word_count), .pkt_count(pkt_count)
    );

    always @(posedge wrclk) if (mon_en && fifo_wrreq) got_q.push_back(fifo_data);

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic lane(input logic [7:0] d, input logic l, input logic f);
        int n = 0;
        @(negedge wrclk);
        in_valid = 1; in_data = d; in_last = l; flush = f;
        #1;
        while (!in_ready && n < 200) begin
            @(negedge wrclk); #1; n++;
        end
        chk("lane_ready", in_ready, 1);
        @(posedge wrclk);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge wrclk);
            in_valid = 0; in_last = 0; flush = 0;
        end
    endtask

    task automatic fl();
        @(negedge wrclk);
        in_valid = 0; in_last = 0; flush = 1;
        @(posedge wrclk);
    endtask

    task automatic drain(input string tag);
        while (exp_q.size() > 0) begin
            chk({tag, "_present"}, got_q.size() > 0, 1);
            if (got_q.size() > 0) chk(tag, got_q.pop_front(), exp_q.pop_front());
            else void'(exp_q.pop_front());
        end
        chk({tag, "_extra"}, got_q.size(), 0);
    endtask

    initial begin
        #1;
        chk("rst_ready", in_ready, 1);
        chk("rst_wrreq", fifo_wrreq, 0);
        chk("rst_wc", word_count, 0);
        chk("rst_pc", pkt_count, 0);
        chk("rst_data", fifo_data, 0);
        repeat (2) @(negedge wrclk);
        aclr = 1;

        // full word, one-cycle write latency
        lane(8'h11, 0, 0); lane(8'h22, 0, 0); lane(8'h33, 0, 0); lane(8'h44, 0, 0);
        idle(1); #1;
        chk("s1_wrreq", fifo_wrreq, 1);
        chk("s1_data", fifo_data, 35'h344332211);
        idle(1); #1;
        chk("s1_wrreq_off", fifo_wrreq, 0);
        chk("s1_wc", word_count, 1);
        exp_q.push_back(35'h344332211);
        drain("s1");

        // short packet ended by in_last
        lane(8'hAA, 0, 0); lane(8'hBB, 1, 0);
        idle(1); #1;
        chk("s2_data", fifo_data, 35'h50000BBAA);
        idle(1); #1;
        chk("s2_pc", pkt_count, 1);
        chk("s2_wc", word_count, 2);
        exp_q.push_back(35'h50000BBAA);
        drain("s2");

        // flush of a partial, flush when empty, flush with an accepted lane
        lane(8'h5A, 0, 0); fl();
        idle(1); #1;
        chk("s4_wrreq", fifo_wrreq, 1);
        chk("s4_data", fifo_data, 35'h00000005A);
        idle(1); #1;
        chk("s4_wc", word_count, 3);
        fl();
        idle(2); #1;
        chk("s4_empty_wrreq", fifo_wrreq, 0);
        chk("s4_empty_wc", word_count, 3);
        lane(8'h01, 0, 0); lane(8'h02, 0, 0); lane(8'h03, 0, 1);
        idle(2); #1;
        chk("s4_flush_lane_wc", word_count, 4);
        exp_q.push_back(35'h00000005A);
        exp_q.push_back(35'h200030201);
        drain("s4");

        // FIFO full for 10 cycles during a 3-word stream
        fifo_wr_full = 1;
        lane(8'h10, 0, 0); lane(8'h11, 0, 0); lane(8'h12, 0, 0); lane(8'h13, 0, 0);
        @(negedge wrclk);
        in_valid = 1; in_data = 8'h14; in_last = 0;
        #1;
        chk("s3_stall_ready", in_ready, 0);
        chk("s3_stall_wrreq", fifo_wrreq, 0);
        repeat (10) begin
            @(negedge wrclk); #1;
            chk("s3_hold_ready", in_ready, 0);
            chk("s3_hold_data", fifo_data, 35'h313121110);
        end
        @(negedge wrclk);
        fifo_wr_full = 0; in_valid = 0;
        for (int i = 8'h14; i <= 8'h1B; i++) lane(8'(i), 0, 0);
        idle(2); #1;
        chk("s3_wc", word_count, 7);
        chk("s3_pc", pkt_count, 1);
        exp_q.push_back(35'h313121110);
        exp_q.push_back(35'h317161514);
        exp_q.push_back(35'h31B1A1918);
        drain("s3");

        // reset mid-packet
        lane(8'hA1, 0, 0); lane(8'hA2, 0, 0);
        idle(1); #1;
        aclr = 0;
        #1;
        chk("s5_ready", in_ready, 1);
        chk("s5_wrreq", fifo_wrreq, 0);
        chk("s5_wc", word_count, 0);
        chk("s5_pc", pkt_count, 0);
        chk("s5_data", fifo_data, 0);
        got_q.delete();
        @(negedge wrclk);
        aclr = 1;
        lane(8'h01, 0, 0); lane(8'h02, 0, 0); lane(8'h03, 0, 0); lane(8'h04, 0, 0);
        idle(2); #1;
        chk("s5_wc_after", word_count, 1);
        exp_q.push_back(35'h304030201);
        drain("s5");

        // 65536 more single-lane words wrap word_count back to 1
        mon_en = 0;
        @(negedge wrclk);
        in_valid = 1; in_last = 1; in_data = 8'h77;
        repeat (65536) @(posedge wrclk);
        idle(2); #1;
        chk("s6_wc_wrap", word_count, 1);
        chk("s6_pc_wrap", pkt_count, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_wr_packer.md
FIFO_WR_PACKER -- requirements
Module: fifo_wr_packer

Interface
REQ-001 Parameter IN_WIDTH, default 8, input byte-lane width in bits.
REQ-002 Parameter RATIO, default 4, lanes per packed word; power of two, at least 2.
REQ-003 Parameter LLOG2, default 2, log2(RATIO).
REQ-004 Derived constants: OUT_WIDTH = IN_WIDTH*RATIO = 32; FIFO_WIDTH = OUT_WIDTH+1+LLOG2 = 35.
REQ-005 Reset aclr, asynchronous, active-low; clock wrclk.
REQ-006 wrclk  in  1  sole clock; every register is on its rising edge.
REQ-007 aclr  in  1  asynchronous active-low reset.
REQ-008 in_data  in  IN_WIDTH  input lane data.
REQ-009 in_valid  in  1  in_data is valid.
REQ-010 in_last  in  1  the current lane ends its packet.
REQ-011 in_ready  out  1  the block accepts a lane this cycle.
REQ-012 flush  in  1  one-cycle pulse; forces out the partial word.
REQ-013 fifo_data  out  FIFO_WIDTH  {last, nlanes-1, word}; drives the async FIFO data port.
REQ-014 fifo_wrreq  out  1  FIFO write request.
REQ-015 fifo_wr_full  in  1  write-side full flag from the FIFO.
REQ-016 word_count  out  16  count of words written to the FIFO; wraps at 16 bits.
REQ-017 pkt_count  out  16  count of words written with last set; wraps at 16 bits.

Function
REQ-018 A lane is accepted when in_valid and in_ready are both high.
REQ-019 Lane k of a word maps to word bits [k*IN_WIDTH +: IN_WIDTH], lane 0 first.
REQ-020 The lane counter increments on each accepted lane and returns to 0 when a word closes.
REQ-021 A word closes on any of these accepted-lane conditions:
- counter at RATIO-1;
- in_last high;
- flush high with counter nonzero and no lane accepted that cycle.
REQ-022 On closure, the assembled word moves into the hold register on the next edge, as follows:
- unfilled lanes are zero;
- nlanes-1 is the count of valid lanes minus 1;
- last = in_last, or 0 for a flush closure.
REQ-023 Three states:
- EMPTY: counter 0, hold empty.
- FILL: counter nonzero, hold empty.
- HOLD: hold occupied, counter any value.
REQ-024 State transitions:
- EMPTY to FILL on an accepted non-closing lane.
- EMPTY or FILL to HOLD on closure.
- HOLD to FILL or EMPTY when the held word is written and no new closure occurs.
- HOLD to HOLD when the held word is written and a closure occurs in the same cycle.
REQ-025 fifo_wrreq = hold_valid AND NOT fifo_wr_full (combinational); fifo_data = hold register.
REQ-026 in_ready = NOT hold_valid OR NOT fifo_wr_full; this gives full throughput of one word every RATIO cycles.
REQ-027 Latency: fifo_wrreq asserts in the cycle after the closing lane is accepted, provided the FIFO is not full.
REQ-028 While fifo_wr_full is high and hold is occupied, the block holds as follows:
- in_ready stays low;
- the hold register and lane counter stay stable;
- no data is lost.
REQ-029 flush with counter 0 and hold empty is ignored.
REQ-030 flush coincident with an accepted lane: the lane is included in the word, then the word closes.
REQ-031 word_count increments by 1 on each fifo_wrreq; pkt_count increments when fifo_wrreq is high and last = 1.

Reset
REQ-032 On aclr low, the following clear immediately:
- state to EMPTY;
- lane counter, assembly register and hold register to 0;
- hold_valid, fifo_wrreq and both counts to 0.
REQ-033 On aclr low, in_ready goes to 1.
REQ-034 A reset in mid-packet discards the partial and held words; the first lane after release starts lane 0.
REQ-035 Reset release is synchronised to wrclk by the instantiating level.

Structure
REQ-036 A shared package fifo_pack_pkg holds the following, for reuse by the matching read-side unpacker:
- state enum (EMPTY, FILL, HOLD);
- FIFO_WIDTH derivation;
- field offsets of last and nlanes.
REQ-037 The block has a single module with no sub-modules; it connects directly to the async FIFO write port (data, wrreq, wr_full).

Verification
REQ-038 Scenario: lanes 11,22,33,44, FIFO not full -> fifo_data word 0x44332211, nlanes-1=3, last=0; fifo_wrreq for one cycle; word_count=1.
REQ-039 Scenario: lanes AA,BB with in_last on BB -> word 0x0000BBAA, nlanes-1=1, last=1; pkt_count=1.
REQ-040 Scenario: fifo_wr_full held high for 10 cycles during a 3-word stream -> in_ready low after the first word closes; on release the words reach the FIFO in order with no loss or duplicate.
REQ-041 Scenario: one lane 5A then a flush pulse -> word 0x0000005A, nlanes-1=0, last=0; a flush when EMPTY produces no write.
REQ-042 Scenario: aclr pulsed after 2 lanes, then lanes 01..04 -> single word 0x04030201; word_count=1.
REQ-043 Scenario: 65537 words written -> word_count=1 (wrap).
